// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode FIFO; enq_* valid/ready in, deq_* valid/ready out (NOP bubble when empty), flush_i redirect, count_o/full_o/empty_o status
module fetch_queue #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit BYPASS = 1'b0,
  parameter logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h00000013)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq_valid_i,
  output logic                         enq_ready_o,
  input  logic [AWIDTH-1:0]            enq_pc_i,
  input  logic [DWIDTH-1:0]            enq_insn_i,
  output logic                         deq_valid_o,
  input  logic                         deq_ready_i,
  output logic [AWIDTH-1:0]            deq_pc_o,
  output logic [DWIDTH-1:0]            deq_insn_o,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AWIDTH+DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH+DWIDTH-1:0] head;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic empty, byp, wr_en, rd_en;
  always_comb begin
    empty = count_q == '0;
    byp = BYPASS && empty && enq_valid_i;
    enq_ready_o = count_q != CW'(DEPTH);
    deq_valid_o = !flush_i && (!empty || byp);
    head = byp ? {enq_pc_i, enq_insn_i} : mem_q[rd_q];
    deq_pc_o = deq_valid_o ? head[AWIDTH+DWIDTH-1:DWIDTH] : '0;
    deq_insn_o = deq_valid_o ? head[DWIDTH-1:0] : NOP_INSN;
    wr_en = !flush_i && enq_valid_i && enq_ready_o && !(byp && deq_ready_i);
    rd_en = deq_valid_o && deq_ready_i && !empty;
    wr_d = flush_i ? '0 : wr_q + PW'(wr_en);
    rd_d = flush_i ? '0 : rd_q + PW'(rd_en);
    count_d = flush_i ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
    count_o = count_q;
    full_o = !enq_ready_o;
    empty_o = empty;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= {enq_pc_i, enq_insn_i};
  cover property (@(posedge clk) disable iff (reset) deq_ready_i && !deq_valid_o);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven check of fetch_queue with BYPASS=0 and BYPASS=1 instances sharing stimulus
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] PA = 32'h01000000, IA = 32'h00500093;
  localparam logic [31:0] PB = 32'h01000004, IB = 32'h00A00113;
  localparam logic [31:0] PC = 32'h01000008, IC = 32'h002081B3;
  localparam logic [31:0] PD = 32'h0100000C, ID = 32'h00308233;
  localparam logic [31:0] PE = 32'h01000010, IE = 32'h00400293;
  localparam logic [31:0] PF = 32'h01000020, IF = 32'h00000073;
  localparam logic [31:0] PG = 32'h01000024, IG = 32'h00100313;
  typedef struct {
    logic rst, fl, ev, dr, ck;
    logic [31:0] pc, in;
    logic [2:0] c0;
    logic v0;
    logic [31:0] p0, i0;
    logic [2:0] c1;
    logic v1;
    logic [31:0] p1, i1;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, ev = 1'b0, dr = 1'b0, fl = 1'b0;
  logic [31:0] epc = '0, ein = '0;
  logic rdy0, dv0, full0, emp0, rdy1, dv1, full1, emp1;
  logic [31:0] pc0, in0, pc1, in1;
  logic [2:0] cnt0, cnt1;
  int n_chk = 0, n_err = 0;
  vec_t tv [18];
  always #5 clk = ~clk;
  fetch_queue #(.BYPASS(1'b0)) u0 (.clk(clk), .reset(reset), .enq_valid_i(ev), .enq_ready_o(rdy0),
    .enq_pc_i(epc), .enq_insn_i(ein), .deq_valid_o(dv0), .deq_ready_i(dr), .deq_pc_o(pc0),
    .deq_insn_o(in0), .flush_i(fl), .count_o(cnt0), .full_o(full0), .empty_o(emp0));
  fetch_queue #(.BYPASS(1'b1)) u1 (.clk(clk), .reset(reset), .enq_valid_i(ev), .enq_ready_o(rdy1),
    .enq_pc_i(epc), .enq_insn_i(ein), .deq_valid_o(dv1), .deq_ready_i(dr), .deq_pc_o(pc1),
    .deq_insn_o(in1), .flush_i(fl), .count_o(cnt1), .full_o(full1), .empty_o(emp1));
  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, a, e, $time);
    end
  endtask
  task automatic chk_dut(input int id, input logic [2:0] c, input logic v, input logic [31:0] p, input logic [31:0] i);
    if (id == 0) begin
      chk("u0.count", 64'(cnt0), 64'(c));
      chk("u0.valid", 64'(dv0), 64'(v));
      chk("u0.pc", 64'(pc0), 64'(p));
      chk("u0.insn", 64'(in0), 64'(i));
      chk("u0.full", 64'(full0), 64'(c == 3'd4));
      chk("u0.empty", 64'(emp0), 64'(c == 3'd0));
      chk("u0.ready", 64'(rdy0), 64'(c != 3'd4));
    end else begin
      chk("u1.count", 64'(cnt1), 64'(c));
      chk("u1.valid", 64'(dv1), 64'(v));
      chk("u1.pc", 64'(pc1), 64'(p));
      chk("u1.insn", 64'(in1), 64'(i));
      chk("u1.full", 64'(full1), 64'(c == 3'd4));
      chk("u1.empty", 64'(emp1), 64'(c == 3'd0));
      chk("u1.ready", 64'(rdy1), 64'(c != 3'd4));
    end
  endtask
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      reset = tv[i].rst; fl = tv[i].fl; ev = tv[i].ev; dr = tv[i].dr; epc = tv[i].pc; ein = tv[i].in;
      #2;
      if (tv[i].ck) begin
        chk_dut(0, tv[i].c0, tv[i].v0, tv[i].p0, tv[i].i0);
        chk_dut(1, tv[i].c1, tv[i].v1, tv[i].p1, tv[i].i1);
      end
    end
  endtask
  task automatic wrap();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = 1'b0; fl = 1'b0; ev = 1'b1; dr = 1'b1;
      epc = PE + 32'(4 * k); ein = 32'h100 + 32'(k);
      #2;
      chk("wrap.u0.pc", 64'(pc0), 64'(PB + 32'(4 * k)));
      chk("wrap.u1.pc", 64'(pc1), 64'(PB + 32'(4 * k)));
      chk("wrap.u0.count", 64'(cnt0), 64'd3);
      chk("wrap.u1.count", 64'(cnt1), 64'd3);
      if (k >= 3) chk("wrap.u0.insn", 64'(in0), 64'(32'h100 + 32'(k - 3)));
    end
  endtask
  initial begin
    tv[0]  = '{1,0,0,0,0, 0,0,   0,0,0,NOP,   0,0,0,NOP};
    tv[1]  = '{0,0,0,0,1, 0,0,   0,0,0,NOP,   0,0,0,NOP};
    tv[2]  = '{0,0,1,0,1, PA,IA, 0,0,0,NOP,   0,1,PA,IA};
    tv[3]  = '{0,0,1,0,1, PB,IB, 1,1,PA,IA,   1,1,PA,IA};
    tv[4]  = '{0,0,1,0,1, PC,IC, 2,1,PA,IA,   2,1,PA,IA};
    tv[5]  = '{0,0,0,0,1, 0,0,   3,1,PA,IA,   3,1,PA,IA};
    tv[6]  = '{0,0,1,0,1, PD,ID, 3,1,PA,IA,   3,1,PA,IA};
    tv[7]  = '{0,0,1,1,1, PE,IE, 4,1,PA,IA,   4,1,PA,IA};
    tv[8]  = '{0,0,0,0,1, 0,0,   3,1,PB,IB,   3,1,PB,IB};
    tv[9]  = '{0,1,1,0,1, PE,IE, 3,0,0,NOP,   3,0,0,NOP};
    tv[10] = '{0,0,0,0,1, 0,0,   0,0,0,NOP,   0,0,0,NOP};
    tv[11] = '{0,0,1,1,1, PF,IF, 0,0,0,NOP,   0,1,PF,IF};
    tv[12] = '{0,0,1,0,1, PF,IF, 1,1,PF,IF,   0,1,PF,IF};
    tv[13] = '{0,0,1,0,1, PG,IG, 2,1,PF,IF,   1,1,PF,IF};
    tv[14] = '{1,0,0,0,1, 0,0,   3,1,PF,IF,   2,1,PF,IF};
    tv[15] = '{0,0,0,0,1, 0,0,   0,0,0,NOP,   0,0,0,NOP};
    tv[16] = '{0,1,1,1,1, PG,IG, 0,0,0,NOP,   0,0,0,NOP};
    tv[17] = '{0,0,0,1,1, 0,0,   0,0,0,NOP,   0,0,0,NOP};
    run(0, 8);
    wrap();
    run(9, 17);
    @(negedge clk);
    ev = 1'b0; dr = 1'b0;
    #2;
    chk("u0.empty_deq_ignored", 64'(cnt0), 64'd0);
    chk("u1.empty_deq_ignored", 64'(cnt1), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
